// File: rtl/vwi_rx_decoder.sv
// Receive endpoint of the virtual-wire sideband channel: rebuilds the far die's
// wire vector from chunked UPDATE/SYNC messages, falling back to straps when the link is down.
module vwi_rx_decoder #(
    parameter int V_WIRES    = 64,
    parameter int CHUNK_W    = 16,
    parameter int NUM_CHUNKS = V_WIRES / CHUNK_W,
    parameter int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1,
    parameter int SEQ_W      = 4
) (
    input  logic               d2d_sb_clk,
    input  logic               d2d_sb_rst,
    input  logic               ip_ready,
    input  logic [V_WIRES-1:0] strap_default_wires_out,
    input  logic               msg_valid,
    output logic               msg_ready,
    input  logic [1:0]         msg_opcode,
    input  logic [IDX_W-1:0]   msg_chunk_idx,
    input  logic [CHUNK_W-1:0] msg_data,
    input  logic [SEQ_W-1:0]   msg_seq,
    output logic [V_WIRES-1:0] async_virt_out,
    output logic               ack_valid,
    output logic [SEQ_W-1:0]   ack_seq,
    output logic               resync_req,
    output logic               seq_err,
    output logic               bad_msg
);

    typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_ACTIVE} state_e;

    localparam logic [1:0] OP_UPDATE = 2'b00;
    localparam logic [1:0] OP_SYNC   = 2'b01;

    state_e                state_q, state_d;
    logic [V_WIRES-1:0]    virt_q, virt_d;
    logic [V_WIRES-1:0]    shadow_q, shadow_d;
    logic [NUM_CHUNKS-1:0] bitmap_q, bitmap_d;
    logic [SEQ_W-1:0]      exp_seq_q, exp_seq_d;
    logic                  ack_valid_q, ack_valid_d;
    logic [SEQ_W-1:0]      ack_seq_q, ack_seq_d;
    logic                  resync_req_q, resync_req_d;
    logic                  seq_err_q, seq_err_d;
    logic                  bad_msg_q, bad_msg_d;

    logic                  accept;
    logic                  illegal;
    int unsigned           chunk_lsb;

    assign msg_ready = (state_q != ST_IDLE);
    assign accept    = msg_valid & msg_ready;
    assign illegal   = (32'(msg_chunk_idx) >= NUM_CHUNKS) ||
                       (msg_opcode != OP_UPDATE && msg_opcode != OP_SYNC);
    assign chunk_lsb = 32'(msg_chunk_idx) * CHUNK_W;

    always_comb begin
        state_d     = state_q;
        virt_d      = virt_q;
        shadow_d    = shadow_q;
        bitmap_d    = bitmap_q;
        exp_seq_d   = exp_seq_q;
        ack_valid_d = 1'b0;
        ack_seq_d   = ack_seq_q;
        seq_err_d   = 1'b0;
        bad_msg_d   = 1'b0;

        if (state_q == ST_IDLE) begin
            virt_d   = strap_default_wires_out;
            bitmap_d = '0;
            if (ip_ready) state_d = ST_SYNC;
        end else if (!ip_ready) begin
            // link loss outranks any message accepted in the same cycle
            state_d  = ST_IDLE;
            virt_d   = strap_default_wires_out;
            bitmap_d = '0;
        end else if (accept) begin
            if (illegal) begin
                bad_msg_d = 1'b1;
            end else if (msg_opcode == OP_UPDATE) begin
                if (state_q == ST_SYNC) begin
                    bad_msg_d = 1'b1;
                end else if (msg_seq == exp_seq_q) begin
                    virt_d[chunk_lsb +: CHUNK_W] = msg_data;
                    ack_valid_d = 1'b1;
                    ack_seq_d   = msg_seq;
                    exp_seq_d   = exp_seq_q + 1'b1;
                end else begin
                    seq_err_d = 1'b1;
                    state_d   = ST_SYNC;
                    bitmap_d  = '0;
                end
            end else begin
                // SYNC from ACTIVE restarts collection with this chunk as the first one
                if (state_q == ST_ACTIVE) bitmap_d = '0;
                shadow_d[chunk_lsb +: CHUNK_W] = msg_data;
                bitmap_d[msg_chunk_idx]        = 1'b1;
                state_d                        = ST_SYNC;
                if (&bitmap_d) begin
                    virt_d    = shadow_d;
                    exp_seq_d = '0;
                    bitmap_d  = '0;
                    state_d   = ST_ACTIVE;
                end
            end
        end

        resync_req_d = (state_d == ST_SYNC);
    end

    always_ff @(posedge d2d_sb_clk) begin
        if (d2d_sb_rst) begin
            state_q      <= ST_IDLE;
            virt_q       <= strap_default_wires_out;
            shadow_q     <= '0;
            bitmap_q     <= '0;
            exp_seq_q    <= '0;
            ack_valid_q  <= 1'b0;
            ack_seq_q    <= '0;
            resync_req_q <= 1'b0;
            seq_err_q    <= 1'b0;
            bad_msg_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            virt_q       <= virt_d;
            shadow_q     <= shadow_d;
            bitmap_q     <= bitmap_d;
            exp_seq_q    <= exp_seq_d;
            ack_valid_q  <= ack_valid_d;
            ack_seq_q    <= ack_seq_d;
            resync_req_q <= resync_req_d;
            seq_err_q    <= seq_err_d;
            bad_msg_q    <= bad_msg_d;
        end
    end

    assign async_virt_out = virt_q;
    assign ack_valid      = ack_valid_q;
    assign ack_seq        = ack_seq_q;
    assign resync_req     = resync_req_q;
    assign seq_err        = seq_err_q;
    assign bad_msg        = bad_msg_q;

endmodule

// File: tb/tb_vwi_rx_decoder.sv
// Bench for vwi_rx_decoder: directed scenarios with fixed expectations, then a
// randomized run checked against a chunk-array model of the channel rules.
module tb_vwi_rx_decoder;

    localparam logic [63:0] S0 = 64'hA5A5_0000_FFFF_1234;
    localparam logic [63:0] S1 = 64'h0123_4567_89AB_CDEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        ip_ready;
    logic [63:0] straps;
    logic        msg_valid;
    logic        msg_ready;
    logic [1:0]  msg_opcode;
    logic [1:0]  msg_chunk_idx;
    logic [15:0] msg_data;
    logic [3:0]  msg_seq;
    logic [63:0] virt;
    logic        ack_valid;
    logic [3:0]  ack_seq;
    logic        resync_req;
    logic        seq_err;
    logic        bad_msg;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_virt;

    // reference model: link mode 0=down 1=collecting sync 2=running
    int          m_mode;
    logic [15:0] m_wires[4];
    logic [15:0] m_shadow[4];
    bit          m_got[4];
    int          m_exp;
    bit          m_ack, m_err, m_bad;
    int          m_ack_seq;

    vwi_rx_decoder #(
        .V_WIRES(64), .CHUNK_W(16), .NUM_CHUNKS(4), .IDX_W(2), .SEQ_W(4)
    ) dut (
        .d2d_sb_clk(clk), .d2d_sb_rst(rst), .ip_ready(ip_ready),
        .strap_default_wires_out(straps), .msg_valid(msg_valid), .msg_ready(msg_ready),
        .msg_opcode(msg_opcode), .msg_chunk_idx(msg_chunk_idx), .msg_data(msg_data),
        .msg_seq(msg_seq), .async_virt_out(virt), .ack_valid(ack_valid),
        .ack_seq(ack_seq), .resync_req(resync_req), .seq_err(seq_err), .bad_msg(bad_msg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [1:0] idx,
                        input logic [15:0] data, input logic [3:0] seq);
        msg_valid = 1'b1; msg_opcode = op; msg_chunk_idx = idx;
        msg_data = data; msg_seq = seq;
    endtask

    task automatic model_step();
        bit all;
        m_ack = 0; m_err = 0; m_bad = 0;
        if (rst) begin
            m_mode = 0; m_exp = 0; m_ack_seq = 0;
            for (int i = 0; i < 4; i++) begin
                m_wires[i] = straps[16*i +: 16]; m_shadow[i] = '0; m_got[i] = 0;
            end
        end else if (m_mode == 0) begin
            for (int i = 0; i < 4; i++) m_wires[i] = straps[16*i +: 16];
            if (ip_ready) m_mode = 1;
        end else if (!ip_ready) begin
            m_mode = 0;
            for (int i = 0; i < 4; i++) begin m_wires[i] = straps[16*i +: 16]; m_got[i] = 0; end
        end else if (msg_valid) begin
            if (msg_opcode > 2'd1) m_bad = 1;
            else if (msg_opcode == 2'd0) begin
                if (m_mode == 1) m_bad = 1;
                else if (int'(msg_seq) == m_exp) begin
                    m_wires[msg_chunk_idx] = msg_data;
                    m_ack = 1; m_ack_seq = int'(msg_seq); m_exp = (m_exp + 1) % 16;
                end else begin
                    m_err = 1; m_mode = 1;
                    for (int i = 0; i < 4; i++) m_got[i] = 0;
                end
            end else begin
                if (m_mode == 2) for (int i = 0; i < 4; i++) m_got[i] = 0;
                m_mode = 1;
                m_shadow[msg_chunk_idx] = msg_data;
                m_got[msg_chunk_idx] = 1;
                all = m_got[0] && m_got[1] && m_got[2] && m_got[3];
                if (all) begin
                    for (int i = 0; i < 4; i++) begin m_wires[i] = m_shadow[i]; m_got[i] = 0; end
                    m_exp = 0; m_mode = 2;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1; ip_ready = 0; straps = S0; msg_valid = 0;
        msg_opcode = 0; msg_chunk_idx = 0; msg_data = 0; msg_seq = 0;
        tick(); tick();
        rst = 0;
        tick(); tick(); tick();
        checks++; if (virt !== S0) begin failures++; $display("FAIL reset_virt got=%h exp=%h", virt, S0); end
        checks++; if (msg_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", msg_ready); end
        checks++; if (resync_req !== 1'b0) begin failures++; $display("FAIL reset_resync got=%b exp=0", resync_req); end
        checks++; if ({ack_valid, seq_err, bad_msg} !== 3'b000) begin failures++;
            $display("FAIL reset_pulses got=%b exp=000", {ack_valid, seq_err, bad_msg}); end
        send(2'b01, 2'd0, 16'hDEAD, 4'd0);
        tick();
        checks++; if (bad_msg !== 1'b0 || virt !== S0) begin failures++;
            $display("FAIL idle_ignore got bad=%b virt=%h exp bad=0 virt=%h", bad_msg, virt, S0); end
        msg_valid = 0;
    endtask

    task automatic test_sync_commit();
        logic [15:0] d[4];
        d[0] = 16'h1111; d[1] = 16'h2222; d[2] = 16'h3333; d[3] = 16'h4444;
        ip_ready = 1;
        tick();
        checks++; if (msg_ready !== 1'b1 || resync_req !== 1'b1) begin failures++;
            $display("FAIL sync_entry got ready=%b resync=%b exp 1 1", msg_ready, resync_req); end
        for (int i = 0; i < 4; i++) begin
            send(2'b01, 2'(i), d[i], 4'd0);
            tick();
            if (i < 3) begin
                checks++; if (virt !== S0 || resync_req !== 1'b1) begin failures++;
                    $display("FAIL sync_hold%0d got virt=%h resync=%b exp virt=%h resync=1", i, virt, resync_req, S0); end
            end
        end
        msg_valid = 0;
        exp_virt = 64'h4444_3333_2222_1111;
        checks++; if (virt !== exp_virt) begin failures++; $display("FAIL sync_commit got=%h exp=%h", virt, exp_virt); end
        checks++; if (resync_req !== 1'b0 || msg_ready !== 1'b1) begin failures++;
            $display("FAIL sync_active got resync=%b ready=%b exp 0 1", resync_req, msg_ready); end
    endtask

    task automatic test_update_wrap();
        int acks = 0;
        logic [1:0]  idx;
        logic [15:0] data;
        for (int n = 0; n < 17; n++) begin
            idx  = (n == 0) ? 2'd2 : 2'($urandom_range(0, 3));
            data = (n == 0) ? 16'hBEEF : 16'($urandom);
            send(2'b00, idx, data, 4'(n % 16));
            tick();
            exp_virt[16*idx +: 16] = data;
            if (ack_valid === 1'b1) acks++;
            checks++; if (ack_valid !== 1'b1 || ack_seq !== 4'(n % 16) || seq_err !== 1'b0) begin failures++;
                $display("FAIL upd_ack%0d got ack=%b seq=%0d err=%b exp 1 %0d 0", n, ack_valid, ack_seq, seq_err, n % 16); end
            checks++; if (virt !== exp_virt) begin failures++;
                $display("FAIL upd_virt%0d got=%h exp=%h", n, virt, exp_virt); end
        end
        msg_valid = 0;
        tick();
        checks++; if (acks != 17 || ack_valid !== 1'b0) begin failures++;
            $display("FAIL upd_count got acks=%0d ack=%b exp 17 0", acks, ack_valid); end
    endtask

    task automatic test_seq_err();
        send(2'b00, 2'd0, 16'hAAAA, 4'd1); tick(); exp_virt[15:0] = 16'hAAAA;
        send(2'b00, 2'd1, 16'hBBBB, 4'd2); tick(); exp_virt[31:16] = 16'hBBBB;
        send(2'b11, 2'd3, 16'h9999, 4'd3);
        tick();
        checks++; if (bad_msg !== 1'b1 || virt !== exp_virt || resync_req !== 1'b0) begin failures++;
            $display("FAIL illegal_op got bad=%b virt=%h resync=%b exp 1 %h 0", bad_msg, virt, resync_req, exp_virt); end
        send(2'b00, 2'd3, 16'h7777, 4'd5);
        tick();
        checks++; if (seq_err !== 1'b1 || ack_valid !== 1'b0 || virt !== exp_virt) begin failures++;
            $display("FAIL seq_err got err=%b ack=%b virt=%h exp 1 0 %h", seq_err, ack_valid, virt, exp_virt); end
        checks++; if (resync_req !== 1'b1) begin failures++; $display("FAIL seq_resync got=%b exp=1", resync_req); end
        send(2'b00, 2'd0, 16'h5555, 4'd0);
        tick();
        checks++; if (bad_msg !== 1'b1 || ack_valid !== 1'b0 || seq_err !== 1'b0 || virt !== exp_virt) begin failures++;
            $display("FAIL upd_in_sync got bad=%b ack=%b err=%b virt=%h exp 1 0 0 %h", bad_msg, ack_valid, seq_err, virt, exp_virt); end
        msg_valid = 0;
    endtask

    task automatic test_dup_chunk();
        logic [1:0]  idx[5];
        logic [15:0] d[5];
        idx[0] = 0; idx[1] = 1; idx[2] = 1; idx[3] = 2; idx[4] = 3;
        d[0] = 16'hA000; d[1] = 16'hB001; d[2] = 16'hB111; d[3] = 16'hC002; d[4] = 16'hD003;
        for (int i = 0; i < 5; i++) begin
            send(2'b01, idx[i], d[i], 4'd0);
            tick();
            if (i < 4) begin
                checks++; if (virt !== exp_virt || resync_req !== 1'b1) begin failures++;
                    $display("FAIL dup_hold%0d got virt=%h resync=%b exp %h 1", i, virt, resync_req, exp_virt); end
            end
        end
        msg_valid = 0;
        exp_virt = 64'hD003_C002_B111_A000;
        checks++; if (virt !== exp_virt || resync_req !== 1'b0) begin failures++;
            $display("FAIL dup_commit got virt=%h resync=%b exp %h 0", virt, resync_req, exp_virt); end
    endtask

    task automatic test_link_drop();
        send(2'b00, 2'd0, 16'h1234, 4'd0);
        ip_ready = 0;
        tick();
        msg_valid = 0;
        checks++; if (ack_valid !== 1'b0 || seq_err !== 1'b0 || bad_msg !== 1'b0) begin failures++;
            $display("FAIL drop_pulses got ack=%b err=%b bad=%b exp 0 0 0", ack_valid, seq_err, bad_msg); end
        checks++; if (virt !== S0 || msg_ready !== 1'b0 || resync_req !== 1'b0) begin failures++;
            $display("FAIL drop_state got virt=%h ready=%b resync=%b exp %h 0 0", virt, msg_ready, resync_req, S0); end
        straps = S1;
        tick();
        checks++; if (virt !== S1) begin failures++; $display("FAIL strap_follow got=%h exp=%h", virt, S1); end
        straps = S0;
    endtask

    task automatic test_reset_mid();
        ip_ready = 1;
        tick();
        send(2'b01, 2'd0, 16'hF00D, 4'd0); tick();
        send(2'b01, 2'd1, 16'hF11D, 4'd0);
        rst = 1;
        tick();
        rst = 0; msg_valid = 0; ip_ready = 0;
        checks++; if (virt !== S0 || msg_ready !== 1'b0 || resync_req !== 1'b0 || bad_msg !== 1'b0) begin failures++;
            $display("FAIL reset_mid got virt=%h ready=%b resync=%b bad=%b exp %h 0 0 0", virt, msg_ready, resync_req, bad_msg, S0); end
    endtask

    task automatic test_random();
        logic [63:0] mv;
        rst = 1; ip_ready = 0; msg_valid = 0;
        model_step(); tick();
        rst = 0;
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 299) == 0);
            ip_ready = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 99) == 0) straps = {$urandom, $urandom};
            msg_valid     = ($urandom_range(0, 9) < 7);
            msg_chunk_idx = 2'($urandom_range(0, 3));
            msg_data      = 16'($urandom);
            if ($urandom_range(0, 19) == 0) msg_opcode = 2'($urandom_range(2, 3));
            else if (m_mode == 1) msg_opcode = ($urandom_range(0, 9) < 8) ? 2'b01 : 2'b00;
            else msg_opcode = ($urandom_range(0, 9) < 9) ? 2'b00 : 2'b01;
            msg_seq = ($urandom_range(0, 9) < 9) ? 4'(m_exp) : 4'($urandom);
            checks++; if (msg_ready !== (m_mode != 0)) begin failures++;
                $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, msg_ready, m_mode != 0); end
            model_step();
            tick();
            mv = {m_wires[3], m_wires[2], m_wires[1], m_wires[0]};
            checks++; if (virt !== mv) begin failures++;
                $display("FAIL rnd_virt c=%0d got=%h exp=%h", c, virt, mv); end
            checks++; if (ack_valid !== m_ack || seq_err !== m_err || bad_msg !== m_bad) begin failures++;
                $display("FAIL rnd_pulses c=%0d got=%b%b%b exp=%b%b%b", c, ack_valid, seq_err, bad_msg, m_ack, m_err, m_bad); end
            checks++; if (resync_req !== (m_mode == 1)) begin failures++;
                $display("FAIL rnd_resync c=%0d got=%b exp=%b", c, resync_req, m_mode == 1); end
            if (m_ack) begin
                checks++; if (ack_seq !== 4'(m_ack_seq)) begin failures++;
                    $display("FAIL rnd_ack_seq c=%0d got=%0d exp=%0d", c, ack_seq, m_ack_seq); end
            end
        end
        rst = 0; msg_valid = 0;
    endtask

    initial begin
        test_reset();
        test_sync_commit();
        test_update_wrap();
        test_seq_err();
        test_dup_chunk();
        test_link_drop();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vwi_rx_decoder.md
Name: vwi_rx_decoder

Overview:
- Receive-side endpoint of the virtual-wire sideband channel.
- Accepts chunked virtual-wire messages from the sideband link and reconstructs the far die's wire vector onto `async_virt_out`.
- Falls back to strap defaults whenever the link is down, and rebuilds state through an atomic full-sync.
- Sits between the sideband message demux and the virtual-wire consumer logic, in the `d2d_sb_clk` domain.

Parameters:
- V_WIRES, 64: width of the reconstructed wire vector.
- CHUNK_W, 16: payload bits per message. V_WIRES must be an integer multiple of CHUNK_W.
- NUM_CHUNKS, V_WIRES/CHUNK_W: derived chunk count.
- IDX_W, $clog2(NUM_CHUNKS) with a minimum of 1: chunk index width.
- SEQ_W, 4: update sequence-number width.

Ports:
- d2d_sb_clk  input  1  block clock.
- d2d_sb_rst  input  1  reset, synchronous, active-high.
- ip_ready  input  1  link/IP up; low forces defaults.
- strap_default_wires_out  input  V_WIRES  default wire values.
- msg_valid  input  1  message present.
- msg_ready  output  1  block can accept a message.
- msg_opcode  input  2  00 = UPDATE, 01 = SYNC; other values are illegal.
- msg_chunk_idx  input  IDX_W  chunk position.
- msg_data  input  CHUNK_W  chunk payload.
- msg_seq  input  SEQ_W  sequence number (UPDATE only).
- async_virt_out  output  V_WIRES  reconstructed wires.
- ack_valid  output  1  one-cycle pulse, an UPDATE was applied.
- ack_seq  output  SEQ_W  sequence number of the applied UPDATE.
- resync_req  output  1  level, requests a full sync from the far side.
- seq_err  output  1  one-cycle pulse, sequence mismatch.
- bad_msg  output  1  one-cycle pulse, message dropped as illegal.

Behaviour:
- The clock is `d2d_sb_clk`. Reset is `d2d_sb_rst`, synchronous and active-high.
- Reset values:
  - State = IDLE.
  - async_virt_out = strap_default_wires_out, sampled in the reset cycle.
  - ack_valid, seq_err and bad_msg = 0.
  - resync_req = 0.
  - Expected sequence = 0; shadow register and received-chunk bitmap cleared.
- Handshake: a message is accepted on msg_valid & msg_ready. msg_ready = (state != IDLE) and is combinational from state only. Holding msg_valid while msg_ready=0 has no effect.
- IDLE:
  - async_virt_out reloads strap_default_wires_out every cycle.
  - resync_req = 0.
  - On ip_ready=1, go to SYNC in the next cycle.
- SYNC:
  - resync_req = 1.
  - An accepted SYNC message writes msg_data into shadow[idx] and sets bitmap[idx]. A duplicate idx overwrites the shadow; the bitmap bit is unchanged.
  - When the bitmap becomes all-ones, including the cycle that sets the last bit:
    - the next cycle copies the full shadow (with the final chunk) to async_virt_out atomically;
    - expected sequence = 0, bitmap cleared;
    - state goes to ACTIVE and resync_req drops in that same cycle.
  - An UPDATE accepted in SYNC is dropped: bad_msg pulses, no ack, no sequence change.
- ACTIVE:
  - Accepted UPDATE with msg_seq == expected:
    - in the next cycle, the async_virt_out chunk [idx*CHUNK_W +: CHUNK_W] = msg_data;
    - ack_valid=1 with ack_seq=msg_seq;
    - expected increments modulo 2^SEQ_W (15 wraps to 0).
  - Accepted UPDATE with msg_seq != expected:
    - the message is dropped and seq_err pulses;
    - state goes to SYNC with bitmap cleared; async_virt_out holds its last value.
  - Accepted SYNC:
    - state goes to SYNC with bitmap cleared;
    - the message is processed as the first SYNC chunk (shadow and bitmap written).
- Illegal messages: msg_chunk_idx >= NUM_CHUNKS, or opcode 10/11, in any non-IDLE state.
  - The message is accepted and dropped, and bad_msg pulses.
  - No state change and no output change.
- ip_ready falling in SYNC or ACTIVE:
  - the next cycle goes to IDLE and async_virt_out = straps;
  - any message accepted in that same cycle is discarded, with no ack and no error;
  - the bitmap clears.
- Reset mid-operation: reset wins over all events and applies the reset values in the next cycle.
- Output latency: one cycle from acceptance to async_virt_out, ack_valid, seq_err and bad_msg. There is no back-pressure on the ack or error outputs.

Test Plan:
- Reset, then hold ip_ready=0 with straps = 64'hA5A5_0000_FFFF_1234, and accept no messages → async_virt_out = straps, msg_ready=0, resync_req=0.
- Raise ip_ready, then send SYNC chunks idx 0..3 = 16'h1111, 2222, 3333, 4444 → async_virt_out stays at straps until the cycle after chunk 3, then becomes 64'h4444_3333_2222_1111; resync_req drops and state is ACTIVE.
- In ACTIVE, send UPDATE idx2 data 16'hBEEF seq 0, then seq 1..15, then seq 0 again → bits [47:32] = BEEF one cycle after the first UPDATE; 17 ack pulses with ack_seq 0..15,0; no seq_err.
- In ACTIVE, send UPDATE seq 5 while expected = 3 → seq_err pulses, outputs unchanged, resync_req=1, and a subsequent UPDATE in SYNC gives bad_msg with no ack.
- In SYNC, send chunks 0, 1, 1 (new data), 2, 3 → commit occurs only after chunk 3, and idx 1 carries the later data.
- In ACTIVE, drop ip_ready in the same cycle as an accepted UPDATE → no ack, async_virt_out = straps the next cycle, msg_ready=0.
